systolic_mm_engine: RTL and testbench

- Parametrised output-stationary N×N systolic matrix-multiply engine; successor to the fixed 2×2 single-cycle MAC block.
- Computes C[N×N] = A[N×k] · B[k×N] with runtime inner depth k and a signed/unsigned mode.
- Operands are written into internal buffers, the multiply starts on a start pulse, and results stream out as a byte stream with valid/ready, sized to feed the 8N1 UART transmitter directly.

---
 rtl/systolic_mm_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic matrix multiply C = A[Nxk] * B[kxN], signed or unsigned.
// Latency: first result byte k+2N cycles after the accepted start; bytes then paced by out_ready.
// Backpressure: out_byte/out_last are held while out_valid & !out_ready; nothing advances without a handshake.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_signed, cfg_k      operand mode and inner depth, captured on an accepted start
//   wr_en/wr_sel/wr_addr/wr_data   operand buffer write port (A: r*K_MAX+k, B: k*N+c), IDLE only
//   start, busy, err, done run control and status
//   out_valid/out_ready/out_byte/out_last   result byte stream, MSB byte of each result first
module systolic_mm_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 2,
    parameter int K_MAX      = 4,
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(K_MAX),
    localparam int OUT_BYTES = (ACC_WIDTH + 7) / 8,
    localparam int KW        = $clog2(K_MAX) + 1,
    localparam int AW        = $clog2(N * K_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_signed,
    input  logic [KW-1:0]         cfg_k,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_last,
    output logic                  done
);

    localparam int FW = $clog2(K_MAX + 2 * N);
    localparam int RW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int BW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int OW = OUT_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_STREAM
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] a_buf [N*K_MAX];
    logic [DATA_WIDTH-1:0] b_buf [N*K_MAX];

    logic [KW-1:0] k_q;
    logic          mode_q;
    logic [FW-1:0] feed_t;
    logic [RW-1:0] res_idx;
    logic [BW-1:0] byte_idx;

    logic start_ok;
    logic feed_last;
    logic last_byte;
    logic hs;

    logic [DATA_WIDTH-1:0] a_edge [N];
    logic [DATA_WIDTH-1:0] b_edge [N];
    logic [DATA_WIDTH-1:0] a_op   [N][N];
    logic [DATA_WIDTH-1:0] b_op   [N][N];
    logic [ACC_WIDTH-1:0]  acc    [N*N];

    logic [ACC_WIDTH-1:0] sel_acc;
    logic [OW-1:0]        sel_ext;
    logic [BW-1:0]        sel_pos;

    assign start_ok  = start && (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
    assign feed_last = (feed_t == FW'(k_q) + FW'(2 * N - 2));
    assign last_byte = (res_idx == RW'(N * N - 1)) && (byte_idx == BW'(OUT_BYTES - 1));
    assign hs        = (state == S_STREAM) && out_ready;

    // Operand buffers: no reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && wr_en) begin
            if (!wr_sel) begin
                a_buf[wr_addr] <= wr_data;
            end else begin
                b_buf[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            k_q      <= '0;
            mode_q   <= 1'b0;
            feed_t   <= '0;
            res_idx  <= '0;
            byte_idx <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == S_IDLE) && start && !start_ok;
            done  <= hs && last_byte;
            if (state == S_IDLE && start_ok) begin
                k_q    <= cfg_k;
                mode_q <= cfg_signed;
            end
            feed_t <= (state == S_FEED) ? feed_t + 1'b1 : '0;
            if (state != S_STREAM) begin
                res_idx  <= '0;
                byte_idx <= '0;
            end else if (hs) begin
                if (byte_idx == BW'(OUT_BYTES - 1)) begin
                    byte_idx <= '0;
                    res_idx  <= res_idx + 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        out_valid = (state == S_STREAM);
        out_last  = (state == S_STREAM) && last_byte;
        out_byte  = '0;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_FEED;
            S_FEED:   if (feed_last) state_nxt = S_STREAM;
            S_STREAM: if (hs && last_byte) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (state == S_STREAM) begin
            out_byte = sel_ext[8*sel_pos +: 8];
        end
    end

    // Skewed array edges: row r sees A[r][t-r], column c sees B[t-c][c], zero outside 0..k-1.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_edge[r] = '0;
            if (state == S_FEED && feed_t >= FW'(r) && (feed_t - FW'(r)) < FW'(k_q)) begin
                a_edge[r] = a_buf[AW'(r * K_MAX) + AW'(feed_t - FW'(r))];
            end
        end
        for (int c = 0; c < N; c++) begin
            b_edge[c] = '0;
            if (state == S_FEED && feed_t >= FW'(c) && (feed_t - FW'(c)) < FW'(k_q)) begin
                b_edge[c] = b_buf[AW'(feed_t - FW'(c)) * AW'(N) + AW'(c)];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic signed [DATA_WIDTH:0]     a_x;
            logic signed [DATA_WIDTH:0]     b_x;
            logic signed [2*DATA_WIDTH+1:0] prod;
            logic [ACC_WIDTH-1:0]           acc_q;

            // Each PE's operand is either the array edge or a register holding
            // the neighbour's operand from the previous cycle.
            if (c == 0) begin : g_a_edge
                assign a_op[r][c] = a_edge[r];
            end else begin : g_a_pipe
                logic [DATA_WIDTH-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                    end else if (state == S_CLEAR) begin
                        a_q <= '0;
                    end else if (state == S_FEED) begin
                        a_q <= a_op[r][c-1];
                    end
                end
                assign a_op[r][c] = a_q;
            end

            if (r == 0) begin : g_b_edge
                assign b_op[r][c] = b_edge[c];
            end else begin : g_b_pipe
                logic [DATA_WIDTH-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        b_q <= '0;
                    end else if (state == S_CLEAR) begin
                        b_q <= '0;
                    end else if (state == S_FEED) begin
                        b_q <= b_op[r-1][c];
                    end
                end
                assign b_op[r][c] = b_q;
            end

            // One extra bit lets a single signed multiplier serve both modes.
            assign a_x  = {mode_q & a_op[r][c][DATA_WIDTH-1], a_op[r][c]};
            assign b_x  = {mode_q & b_op[r][c][DATA_WIDTH-1], b_op[r][c]};
            assign prod = a_x * b_x;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (state == S_CLEAR) begin
                    acc_q <= '0;
                end else if (state == S_FEED) begin
                    acc_q <= acc_q + ACC_WIDTH'(prod);
                end
            end

            assign acc[r*N+c] = acc_q;
        end
    end

    // Result extension to whole bytes; the mask is zero when ACC_WIDTH fills all bytes.
    always_comb begin
        sel_acc = acc[res_idx];
        sel_ext = OW'(sel_acc);
        if (mode_q && sel_acc[ACC_WIDTH-1]) begin
            sel_ext = sel_ext | ~((OW'(1) << ACC_WIDTH) - OW'(1));
        end
        sel_pos = BW'(OUT_BYTES - 1) - byte_idx;
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
`timescale 1ns/1ps
module tb_systolic_mm_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_signed;
    logic [2:0] cfg_k;
    logic       wr_en;
    logic       wr_sel;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       done;

    systolic_mm_engine #(.DATA_WIDTH(8), .N(2), .K_MAX(4)) dut (
        .clk(clk), .rst(rst), .cfg_signed(cfg_signed), .cfg_k(cfg_k),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .err(err), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    bit   bp_en = 0;
    bit   did_long = 0;
    int   stall = 0;
    bit   stall_pend = 0;
    logic [7:0] stall_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: compares every accepted byte against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                checks++;
                if (!out_valid || out_byte !== stall_byte) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0b/%0h expected=1/%0h", out_valid, out_byte, stall_byte);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", out_byte);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_byte !== e.b || out_last !== e.l) begin
                        errors++;
                        $display("FAIL byte%0d actual=%0h/last%0b expected=%0h/last%0b",
                                 hs_cnt, out_byte, out_last, e.b, e.l);
                    end
                end
                hs_cnt++;
            end
            stall_pend = out_valid && !out_ready;
            stall_byte = out_byte;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    // Consumer: always ready, or random readiness with one forced 10-cycle stall.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                out_ready = 1'b1;
            end else begin
                if (out_valid && !did_long) begin
                    did_long = 1;
                    stall = 10;
                end else if (stall == 0 && $urandom_range(0, 15) == 0) begin
                    stall = 10;
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic push_c(input logic [23:0] c0, input logic [23:0] c1,
                          input logic [23:0] c2, input logic [23:0] c3);
        logic [23:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            for (int j = 2; j >= 0; j--) begin
                exp_t e;
                e.b = c[i][8*j +: 8];
                e.l = (i == 3 && j == 0);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[2:0];
        wr_data = d;
    endtask

    task automatic wr_a(input int r, input int k, input logic [7:0] d);
        wr(1'b0, r * 4 + k, d);
    endtask

    task automatic wr_b(input int k, input int c, input logic [7:0] d);
        wr(1'b1, k * 2 + c, d);
    endtask

    task automatic load_identity_case();
        wr_a(0, 0, 8'd1); wr_a(0, 1, 8'd2); wr_a(1, 0, 8'd4); wr_a(1, 1, 8'd5);
        wr_b(0, 0, 8'd1); wr_b(0, 1, 8'd0); wr_b(1, 0, 8'd0); wr_b(1, 1, 8'd1);
    endtask

    task automatic run(input int k, input bit sgn, input bit inject);
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        cfg_k = 3'(k);
        cfg_signed = sgn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (inject) begin
            chk("busy_after_start", busy, 1);
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 8'h07;
            cfg_k = 3'd1; start = 1'b1;
            @(posedge clk);
            #1;
            wr_sel = 1'b1; wr_addr = 3'd3; wr_data = 8'h09;
            @(posedge clk);
            #1;
            wr_en = 1'b0; start = 1'b0;
        end else begin
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("first_valid_latency", n, k + 4);
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("sb_drained", sb.size(), 0);
        chk("busy_low_after", busy, 0);
        chk("no_err_in_run", err_cnt - e0, 0);
    endtask

    task automatic bad_start(input int k);
        int e0, h0;
        e0 = err_cnt;
        h0 = hs_cnt;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        cfg_k = 3'(k);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_start_busy", busy, 0);
        @(negedge clk);
        chk("bad_start_err", err, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("bad_start_err_once", err_cnt - e0, 1);
        chk("bad_start_no_out", hs_cnt - h0, 0);
    endtask

    initial begin
        int h0, n;
        rst = 1'b1;
        cfg_signed = 1'b0;
        cfg_k = 3'd0;
        wr_en = 1'b0;
        wr_sel = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'd0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_byte", out_byte, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Identity multiply, then a back-to-back rerun with no writes.
        load_identity_case();
        push_c(24'h000001, 24'h000002, 24'h000004, 24'h000005);
        run(2, 1'b0, 1'b0);
        push_c(24'h000001, 24'h000002, 24'h000004, 24'h000005);
        run(2, 1'b0, 1'b0);

        // Full depth, all operands 255: 4*255*255 = 260100 = 0x03F804.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                wr_a(r, k, 8'hFF);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 2; c++)
                wr_b(k, c, 8'hFF);
        push_c(24'h03F804, 24'h03F804, 24'h03F804, 24'h03F804);
        run(4, 1'b0, 1'b0);

        // Signed: A=[[-1,2],[3,-4]], B=I; depth-2 rows/cols 2..3 still hold 255 and must be ignored.
        wr_a(0, 0, 8'hFF); wr_a(0, 1, 8'h02); wr_a(1, 0, 8'h03); wr_a(1, 1, 8'hFC);
        wr_b(0, 0, 8'd1); wr_b(0, 1, 8'd0); wr_b(1, 0, 8'd0); wr_b(1, 1, 8'd1);
        push_c(24'hFFFFFF, 24'h000002, 24'h000003, 24'hFFFFFC);
        run(2, 1'b1, 1'b0);
        // Same operands, unsigned.
        push_c(24'h0000FF, 24'h000002, 24'h000003, 24'h0000FC);
        run(2, 1'b0, 1'b0);

        // Rejected starts.
        bad_start(0);
        bad_start(5);

        // Backpressure with random readiness and long stalls.
        bp_en = 1;
        push_c(24'hFFFFFF, 24'h000002, 24'h000003, 24'hFFFFFC);
        run(2, 1'b1, 1'b0);
        push_c(24'h03F804 - 24'h03F804 + 24'h0000FF, 24'h000002, 24'h000003, 24'h0000FC);
        run(2, 1'b0, 1'b0);
        bp_en = 0;

        // Writes and start while busy are ignored.
        push_c(24'hFFFFFF, 24'h000002, 24'h000003, 24'hFFFFFC);
        run(2, 1'b1, 1'b1);

        // Reset after the 5th byte.
        h0 = hs_cnt;
        push_c(24'hFFFFFF, 24'h000002, 24'h000003, 24'hFFFFFC);
        @(posedge clk);
        #1;
        cfg_k = 3'd2;
        cfg_signed = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (hs_cnt < h0 + 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("reached_5th_byte", hs_cnt - h0, 5);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_byte", out_byte, 0);
        chk("midrst_last", out_last, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        load_identity_case();
        push_c(24'h000001, 24'h000002, 24'h000004, 24'h000005);
        run(2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
